multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the 32-bit RISC core.
- Sequences fetch, decode, execute, memory and writeback over a shared ALU and a single memory port.
- Drives the ALU-control inputs (alu_op, imm_sel) and all datapath enables.
- Waits on a memory ready handshake with a timeout, traps on illegal opcodes and bus timeouts, and counts retired instructions.

---
 rtl/multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback for the 32-bit core.
// Latency: 3 to 5 states per instruction plus memory wait cycles; outputs decode from the current state.
// Backpressure: FETCH and MEM_RD/MEM_WR hold until mem_ready, trapping after WAIT_MAX idle cycles.
module multicycle_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             imm_sel,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    EXEC_R = 4'd2,
    EXEC_I = 4'd3,
    ADDR   = 4'd4,
    MEM_RD = 4'd5,
    MEM_WR = 4'd6,
    WB_R   = 4'd7,
    WB_I   = 4'd8,
    WB_MEM = 4'd9,
    BRANCH = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd15
  } state_t;

  localparam logic [3:0] OP_R    = 4'b0000;
  localparam logic [3:0] OP_LW   = 4'b0001;
  localparam logic [3:0] OP_SW   = 4'b0010;
  localparam logic [3:0] OP_BEQ  = 4'b0011;
  localparam logic [3:0] OP_BNE  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_SLTI = 4'b0110;
  localparam logic [3:0] OP_ORI  = 4'b0111;
  localparam logic [3:0] OP_ANDI = 4'b1000;
  localparam logic [3:0] OP_J    = 4'b1001;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // wait_cnt only needs to reach WAIT_MAX-1; keep at least one bit for WAIT_MAX=1
  localparam int             WW        = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
  localparam logic [WW-1:0]  WAIT_LAST = WW'(WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [WW-1:0]     wait_cnt;
  logic              trap_q;
  logic [1:0]        cause_q;
  logic [CNT_W-1:0]  instret_q;
  logic              retire;
  logic              trap_set;
  logic [1:0]        trap_code;
  logic              in_mem_state;
  logic              timeout;

  assign in_mem_state = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
  // mem_ready on the last allowed cycle still completes the access
  assign timeout      = in_mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  // State register; reset abandons any in-flight access and leaves TRAP
  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // Wait counter: counts stalled memory cycles, clears on any exit from a memory state
  always_ff @(posedge clk) begin
    if (reset)                                  wait_cnt <= '0;
    else if (in_mem_state && !mem_ready && !timeout) wait_cnt <= wait_cnt + WW'(1);
    else                                        wait_cnt <= '0;
  end

  // Sticky trap flag and cause, captured on the transition into TRAP
  always_ff @(posedge clk) begin
    if (reset) begin
      trap_q  <= 1'b0;
      cause_q <= 2'b00;
    end else if (trap_set) begin
      trap_q  <= 1'b1;
      cause_q <= trap_code;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W
  always_ff @(posedge clk) begin
    if (reset)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + CNT_W'(1);
  end

  // Next-state and datapath control decode
  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    trap_set   = 1'b0;
    trap_code  = 2'b00;
    mem_req    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    imm_sel    = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;

    unique case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timeout) begin
          trap_set  = 1'b1;
          trap_code = CAUSE_TIMEOUT;
          state_d   = TRAP;
        end
      end
      DECODE: begin
        // PC + (imm<<2) is parked in ALUOut for a possible branch
        alu_src_b = 2'b11;
        case (op)
          OP_R:                             state_d = EXEC_R;
          OP_LW, OP_SW:                     state_d = ADDR;
          OP_BEQ, OP_BNE:                   state_d = BRANCH;
          OP_ADDI, OP_SLTI, OP_ORI, OP_ANDI: state_d = EXEC_I;
          OP_J:                             state_d = JUMP;
          default: begin
            trap_set  = 1'b1;
            trap_code = CAUSE_ILLEGAL;
            state_d   = TRAP;
          end
        endcase
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b11;
        state_d   = WB_R;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        imm_sel   = 1'b1;
        case (op)
          OP_SLTI: alu_op = 2'b01;
          OP_ORI:  alu_op = 2'b10;
          OP_ANDI: alu_op = 2'b11;
          default: alu_op = 2'b00;
        endcase
        state_d = WB_I;
      end
      ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (op == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD, MEM_WR: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mem_read  = (state_q == MEM_RD);
        mem_write = (state_q == MEM_WR);
        if (mem_ready) begin
          if (state_q == MEM_RD) begin
            state_d = WB_MEM;
          end else begin
            state_d = FETCH;
            retire  = 1'b1;
          end
        end else if (timeout) begin
          trap_set  = 1'b1;
          trap_code = CAUSE_TIMEOUT;
          state_d   = TRAP;
        end
      end
      WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
        retire    = 1'b1;
      end
      WB_I: begin
        reg_write = 1'b1;
        state_d   = FETCH;
        retire    = 1'b1;
      end
      WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
        retire     = 1'b1;
      end
      BRANCH: begin
        // ALU control turns alu_op 01/10 into an equal/not-equal compare
        alu_src_a = 1'b1;
        alu_op    = (op == OP_BNE) ? 2'b10 : 2'b01;
        pc_src    = 2'b01;
        pc_write  = alu_zero;
        state_d   = FETCH;
        retire    = 1'b1;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        state_d  = FETCH;
        retire   = 1'b1;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  assign trap       = trap_q;
  assign trap_cause = cause_q;
  assign state      = state_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl with a short memory timeout and a 4-bit retire counter.
// Inputs change 2 ns after each rising edge; outputs are sampled 1 ns later.
// Memory stalls and timeouts are driven explicitly through mem_ready.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] op;
  logic       alu_zero;
  logic       mem_ready;
  logic       mem_req, mem_read, mem_write, iord, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b, alu_op;
  logic       imm_sel, reg_write, reg_dst, mem_to_reg, trap;
  logic [1:0] trap_cause;
  logic [3:0] state;
  logic [3:0] instret;

  int n_pass  = 0;
  int n_total = 0;

  multicycle_ctrl #(.WAIT_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_read(mem_read), .mem_write(mem_write), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_sel(imm_sel), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .trap(trap), .trap_cause(trap_cause),
    .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; op = 4'b0000; alu_zero = 1'b0; mem_ready = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_state", 32'(state), 0);
    chk("rst_instret", 32'(instret), 0);
    chk("rst_trap", 32'(trap), 0);
    chk("rst_cause", 32'(trap_cause), 0);
    chk("rst_memreq", 32'(mem_req), 1);
    chk("rst_irwrite_idle", 32'(ir_write), 0);

    // ADDI: 0,1,3,8,0
    op = 4'b0101; mem_ready = 1'b1; #1;
    chk("addi_irwrite", 32'(ir_write), 1);
    chk("addi_pcwrite", 32'(pc_write), 1);
    tick(); #1;
    chk("addi_decode", 32'(state), 1);
    chk("addi_dec_srcb", 32'(alu_src_b), 3);
    tick(); #1;
    chk("addi_exec", 32'(state), 3);
    chk("addi_aluop", 32'(alu_op), 0);
    chk("addi_immsel", 32'(imm_sel), 1);
    chk("addi_srcb", 32'(alu_src_b), 2);
    tick(); #1;
    chk("addi_wb", 32'(state), 8);
    chk("addi_regwrite", 32'(reg_write), 1);
    chk("addi_regdst", 32'(reg_dst), 0);
    chk("addi_inst_pre", 32'(instret), 0);
    tick(); #1;
    chk("addi_fetch", 32'(state), 0);
    chk("addi_instret", 32'(instret), 1);

    // LW with three stalled MEM_RD cycles; the 4th sits at the timeout boundary
    op = 4'b0001; mem_ready = 1'b1;
    tick(); tick(); #1;
    chk("lw_addr", 32'(state), 4);
    mem_ready = 1'b0;
    tick(); #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_memrd_hold", 32'(state), 5);
      chk("lw_memreq", 32'(mem_req), 1);
      chk("lw_iord", 32'(iord), 1);
      chk("lw_memread", 32'(mem_read), 1);
      tick(); #1;
    end
    chk("lw_memrd_4th", 32'(state), 5);
    mem_ready = 1'b1; #1;
    tick(); #1;
    chk("lw_wbmem", 32'(state), 9);
    chk("lw_memtoreg", 32'(mem_to_reg), 1);
    chk("lw_regwrite", 32'(reg_write), 1);
    tick(); #1;
    chk("lw_instret", 32'(instret), 2);

    // BEQ taken
    op = 4'b0011; alu_zero = 1'b1;
    tick(); tick(); #1;
    chk("beq_state", 32'(state), 10);
    chk("beq_pcwrite", 32'(pc_write), 1);
    chk("beq_pcsrc", 32'(pc_src), 1);
    chk("beq_aluop", 32'(alu_op), 1);
    tick(); #1;
    chk("beq_instret", 32'(instret), 3);

    // BNE not taken
    op = 4'b0100; alu_zero = 1'b0;
    tick(); tick(); #1;
    chk("bne_state", 32'(state), 10);
    chk("bne_pcwrite", 32'(pc_write), 0);
    chk("bne_aluop", 32'(alu_op), 2);
    tick(); #1;
    chk("bne_instret", 32'(instret), 4);

    // Illegal opcode
    op = 4'b1100;
    tick(); tick(); #1;
    chk("ill_state", 32'(state), 15);
    chk("ill_trap", 32'(trap), 1);
    chk("ill_cause", 32'(trap_cause), 1);
    chk("ill_instret", 32'(instret), 4);
    chk("ill_memreq", 32'(mem_req), 0);
    tick(); #1;
    chk("ill_held", 32'(state), 15);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("ill_rst_state", 32'(state), 0);
    chk("ill_rst_trap", 32'(trap), 0);
    chk("ill_rst_cause", 32'(trap_cause), 0);

    // Fetch timeout after exactly 4 stalled cycles
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      chk("to_fetch_hold", 32'(state), 0);
    end
    tick(); #1;
    chk("to_state", 32'(state), 15);
    chk("to_trap", 32'(trap), 1);
    chk("to_cause", 32'(trap_cause), 2);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;

    // Ready on the 4th cycle wins over the timeout
    for (int i = 0; i < 3; i++) tick();
    mem_ready = 1'b1; op = 4'b1001; #1;
    chk("to_edge_fetch", 32'(state), 0);
    tick(); #1;
    chk("to_edge_decode", 32'(state), 1);
    chk("to_edge_trap", 32'(trap), 0);
    tick(); #1;
    chk("j_state", 32'(state), 11);
    chk("j_pcwrite", 32'(pc_write), 1);
    chk("j_pcsrc", 32'(pc_src), 2);
    tick(); #1;
    chk("j_instret", 32'(instret), 1);

    // SW, reset while MEM_WR completes: reset wins
    op = 4'b0010;
    tick(); tick(); mem_ready = 1'b0;
    tick(); #1;
    chk("sw_memwr", 32'(state), 6);
    chk("sw_memwrite", 32'(mem_write), 1);
    chk("sw_memread", 32'(mem_read), 0);
    reset = 1'b1; mem_ready = 1'b1;
    tick();
    reset = 1'b0; #1;
    chk("sw_rst_state", 32'(state), 0);
    chk("sw_rst_instret", 32'(instret), 0);

    // 16 jumps wrap the 4-bit counter
    op = 4'b1001; mem_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick(); tick(); tick();
      if (i == 14) begin
        #1;
        chk("wrap_15", 32'(instret), 15);
      end
    end
    #1;
    chk("wrap_0", 32'(instret), 0);
    chk("wrap_state", 32'(state), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
